parking_gate_ctrl: RTL and testbench

Entry/exit barrier controller directly upstream of the parking occupancy counter. It conditions raw lane sensors and the badge reader, then decides admission from the counter's space-available flags. It drives both barriers and emits the one-cycle car_entered/car_exited event pulses, with university flags, that the occupancy counter consumes. Each lane runs its own FSM; the two FSMs share only the event-collision arbiter.

---
 rtl/parking_gate_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// Parking barrier controller: conditions the lane sensors, runs one FSM per
// lane (entry, exit) and serialises the car_entered/car_exited events for
// the downstream occupancy counter.

// Two-flop synchronizer followed by a consecutive-sample debouncer.
module pgc_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);
  logic       s1, s2;
  logic [3:0] cnt;

  // Accept a new level only after DEBOUNCE_CYCLES identical differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == 4'(DEBOUNCE_CYCLES - 1)) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end
endmodule

// One lane: admission check, barrier drive, pass tracking and timeout.
// The exit lane is given permanently-true space flags, so its CHECK always
// proceeds to OPEN.
module pgc_lane #(
  parameter int GATE_TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor,
  input  logic pass,
  input  logic is_uni,
  input  logic space_uni,
  input  logic space_gen,
  output logic barrier,
  output logic done,
  output logic done_uni,
  output logic denied,
  output logic fault
);
  typedef enum logic [2:0] {IDLE, CHECK, OPEN, PASSING, WAIT_CLEAR} state_t;

  state_t      state, state_n;
  logic        cls, cls_n;
  logic [15:0] tcnt, tcnt_n;
  logic        barrier_n, done_n, done_uni_n, denied_n, fault_n;

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cls      <= 1'b0;
      tcnt     <= '0;
      barrier  <= 1'b0;
      done     <= 1'b0;
      done_uni <= 1'b0;
      denied   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_n;
      cls      <= cls_n;
      tcnt     <= tcnt_n;
      barrier  <= barrier_n;
      done     <= done_n;
      done_uni <= done_uni_n;
      denied   <= denied_n;
      fault    <= fault_n;
    end
  end

  // Next state and next output values; pulses default low.
  always_comb begin
    state_n    = state;
    cls_n      = cls;
    tcnt_n     = tcnt;
    barrier_n  = barrier;
    done_n     = 1'b0;
    done_uni_n = 1'b0;
    denied_n   = 1'b0;
    fault_n    = fault;
    case (state)
      IDLE: begin
        barrier_n = 1'b0;
        if (sensor) begin
          cls_n   = is_uni;
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (cls ? space_uni : space_gen) begin
          state_n   = OPEN;
          barrier_n = 1'b1;
          tcnt_n    = '0;
        end else begin
          denied_n = 1'b1;
          state_n  = WAIT_CLEAR;
        end
      end
      OPEN: begin
        if (pass) begin
          state_n = PASSING;
        end else if (tcnt == 16'(GATE_TIMEOUT - 1)) begin
          fault_n   = 1'b1;
          barrier_n = 1'b0;
          state_n   = WAIT_CLEAR;
        end else begin
          tcnt_n = tcnt + 16'd1;
        end
      end
      PASSING: begin
        if (!pass) begin
          done_n     = 1'b1;
          done_uni_n = cls;
          barrier_n  = 1'b0;
          state_n    = WAIT_CLEAR;
        end
      end
      WAIT_CLEAR: begin
        barrier_n = 1'b0;
        if (!sensor) state_n = IDLE;
      end
      default: begin
        barrier_n = 1'b0;
        state_n   = IDLE;
      end
    endcase
  end
endmodule

module parking_gate_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GATE_TIMEOUT    = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_sensor,
  input  logic       entry_is_uni,
  input  logic       entry_pass_sensor,
  input  logic       exit_sensor,
  input  logic       exit_is_uni,
  input  logic       exit_pass_sensor,
  input  logic       uni_is_vacated_space,
  input  logic       is_vacated_space,
  output logic       entry_barrier_open,
  output logic       exit_barrier_open,
  output logic       car_entered,
  output logic       is_uni_car_entered,
  output logic       car_exited,
  output logic       is_uni_car_exited,
  output logic       entry_denied,
  output logic [1:0] gate_fault
);
  // Lane index 0 = entry, 1 = exit.
  logic [3:0] raw, deb;
  logic [1:0] sensor, pass, is_uni, space_uni, space_gen;
  logic [1:0] barrier, done, done_uni, denied, fault;
  logic       pend, pend_uni;

  assign raw = {exit_pass_sensor, exit_sensor, entry_pass_sensor, entry_sensor};

  for (genvar i = 0; i < 4; i++) begin : g_deb
    pgc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk(clk), .rst(reset), .raw(raw[i]), .level(deb[i])
    );
  end

  assign sensor    = {deb[2], deb[0]};
  assign pass      = {deb[3], deb[1]};
  assign is_uni    = {exit_is_uni, entry_is_uni};
  assign space_uni = {1'b1, uni_is_vacated_space};
  assign space_gen = {1'b1, is_vacated_space};

  for (genvar l = 0; l < 2; l++) begin : g_lane
    pgc_lane #(.GATE_TIMEOUT(GATE_TIMEOUT)) u_lane (
      .clk(clk), .rst(reset),
      .sensor(sensor[l]), .pass(pass[l]), .is_uni(is_uni[l]),
      .space_uni(space_uni[l]), .space_gen(space_gen[l]),
      .barrier(barrier[l]), .done(done[l]), .done_uni(done_uni[l]),
      .denied(denied[l]), .fault(fault[l])
    );
  end

  // An exit that coincides with an entry waits one cycle in the pending slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend     <= 1'b0;
      pend_uni <= 1'b0;
    end else begin
      pend     <= done[1] & done[0];
      pend_uni <= done_uni[1];
    end
  end

  assign entry_barrier_open = barrier[0];
  assign exit_barrier_open  = barrier[1];
  assign car_entered        = done[0];
  assign is_uni_car_entered = done[0] & done_uni[0];
  assign car_exited         = pend | (done[1] & ~done[0]);
  assign is_uni_car_exited  = pend ? pend_uni : (done[1] & ~done[0] & done_uni[1]);
  // Only the entry lane can refuse; the exit lane's flag is structurally 0.
  assign entry_denied       = |denied;
  assign gate_fault         = fault;
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scoreboard bench for parking_gate_ctrl: stimulus pushes expected events,
// a negedge monitor pops and compares each event pulse the DUT presents.
module tb_parking_gate_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       entry_sensor = 0, entry_is_uni = 0, entry_pass_sensor = 0;
  logic       exit_sensor = 0, exit_is_uni = 0, exit_pass_sensor = 0;
  logic       uni_is_vacated_space = 0, is_vacated_space = 0;
  logic       entry_barrier_open, exit_barrier_open;
  logic       car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic       entry_denied;
  logic [1:0] gate_fault;

  parking_gate_ctrl #(.DEBOUNCE_CYCLES(4), .GATE_TIMEOUT(50)) dut (
    .clk(clk), .reset(reset),
    .entry_sensor(entry_sensor), .entry_is_uni(entry_is_uni),
    .entry_pass_sensor(entry_pass_sensor),
    .exit_sensor(exit_sensor), .exit_is_uni(exit_is_uni),
    .exit_pass_sensor(exit_pass_sensor),
    .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
    .entry_barrier_open(entry_barrier_open), .exit_barrier_open(exit_barrier_open),
    .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
    .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
    .entry_denied(entry_denied), .gate_fault(gate_fault)
  );

  always #5 clk = ~clk;

  // kind: 0 = car_entered, 1 = car_exited, 2 = entry_denied
  // delta: required cycles since the previous event, -1 = don't care
  typedef struct { int kind; bit uni; int delta; } ev_t;
  ev_t sbq[$];

  int tests = 0, fails = 0;
  int cyc = 0, last_ev = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input bit uni, input int delta);
    ev_t e;
    e.kind = kind; e.uni = uni; e.delta = delta;
    sbq.push_back(e);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pop one expectation per observed event pulse.
  always @(negedge clk) begin
    if (!reset) begin
      logic [2:0] obs;
      obs = {entry_denied, car_exited, car_entered};
      if (!car_entered) chk("uni_entered_gated", int'(is_uni_car_entered), 0);
      if (!car_exited)  chk("uni_exited_gated", int'(is_uni_car_exited), 0);
      if (car_entered || car_exited)
        chk("no_collision", int'(car_entered & car_exited), 0);
      if (car_entered) chk("barrier_closed_with_event", int'(entry_barrier_open), 0);
      for (int k = 0; k < 3; k++) begin
        if (obs[k]) begin
          if (sbq.size() == 0) begin
            chk("unexpected_event_kind", k, -1);
          end else begin
            ev_t e;
            e = sbq.pop_front();
            chk("event_kind", k, e.kind);
            if (k == 0) chk("event_uni", int'(is_uni_car_entered), int'(e.uni));
            if (k == 1) chk("event_uni", int'(is_uni_car_exited), int'(e.uni));
            if (e.delta >= 0) chk("event_spacing", cyc - last_ev, e.delta);
            last_ev = cyc;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) until the entry barrier is open; returns negedges waited.
  task automatic wait_entry_open(input string name, output int waited);
    waited = 0;
    while (!entry_barrier_open && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!entry_barrier_open) chk(name, 0, 1);
  endtask

  // Drive a full normal pass through the entry lane once the barrier is open.
  task automatic entry_pass_cycle();
    entry_pass_sensor = 1'b1;
    tick(10);
    entry_pass_sensor = 1'b0;
    tick(12);
    entry_sensor = 1'b0;
    tick(12);
  endtask

  initial begin
    int w;
    int open_cnt;
    int seen;

    // Reset state
    tick(3);
    chk("rst_entry_barrier", int'(entry_barrier_open), 0);
    chk("rst_exit_barrier", int'(exit_barrier_open), 0);
    chk("rst_events", int'({car_entered, car_exited, entry_denied}), 0);
    chk("rst_fault", int'(gate_fault), 0);
    reset = 1'b0;
    tick(2);

    // Non-uni car: input is first sampled on the next posedge; 2 sync + 4
    // debounce + 1 CHECK edges after that the barrier is open, i.e. on the
    // 8th negedge after driving.
    is_vacated_space = 1'b1;
    uni_is_vacated_space = 1'b1;
    entry_is_uni = 1'b0;
    entry_sensor = 1'b1;
    w = 0;
    for (int k = 1; k <= 12 && w == 0; k++) begin
      @(negedge clk);
      if (entry_barrier_open) w = k;
    end
    chk("open_latency", w, 8);
    push(0, 1'b0, -1);
    tick(11);
    entry_pass_cycle();
    chk("closed_after_entry", int'(entry_barrier_open), 0);

    // Uni car, no uni space: one denial, barrier never opens.
    uni_is_vacated_space = 1'b0;
    entry_is_uni = 1'b1;
    push(2, 1'b0, -1);
    entry_sensor = 1'b1;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (entry_barrier_open) seen = 1;
    end
    chk("denied_barrier_stays_closed", seen, 0);
    entry_sensor = 1'b0;
    tick(12);
    entry_is_uni = 1'b0;
    uni_is_vacated_space = 1'b1;

    // Glitch immunity: 3-cycle pulses.
    entry_sensor = 1'b1;
    exit_pass_sensor = 1'b1;
    tick(3);
    entry_sensor = 1'b0;
    exit_pass_sensor = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (entry_barrier_open || exit_barrier_open) seen = 1;
    end
    chk("glitch_no_barrier", seen, 0);
    chk("glitch_no_fault", int'(gate_fault), 0);

    // Timeout: approve, never pass; barrier open exactly 50 cycles.
    entry_sensor = 1'b1;
    wait_entry_open("timeout_open", w);
    open_cnt = 0;
    while (entry_barrier_open && open_cnt < 200) begin
      open_cnt++;
      @(negedge clk);
    end
    chk("timeout_open_cycles", open_cnt, 50);
    chk("timeout_fault", int'(gate_fault), 1);
    entry_sensor = 1'b0;
    tick(12);

    // Second car after the timeout is admitted normally; fault stays sticky.
    entry_sensor = 1'b1;
    wait_entry_open("after_timeout_open", w);
    push(0, 1'b0, -1);
    entry_pass_cycle();
    chk("fault_sticky", int'(gate_fault), 1);

    // Collision: uni entry and non-uni exit complete on the same edge.
    entry_is_uni = 1'b1;
    exit_is_uni = 1'b0;
    entry_sensor = 1'b1;
    exit_sensor = 1'b1;
    wait_entry_open("collision_open", w);
    chk("collision_exit_open", int'(exit_barrier_open), 1);
    push(0, 1'b1, -1);
    push(1, 1'b0, 1);
    entry_pass_sensor = 1'b1;
    exit_pass_sensor = 1'b1;
    tick(10);
    entry_pass_sensor = 1'b0;
    exit_pass_sensor = 1'b0;
    tick(12);
    entry_sensor = 1'b0;
    exit_sensor = 1'b0;
    entry_is_uni = 1'b0;
    tick(12);
    chk("collision_queue_drained", sbq.size(), 0);

    // Async reset while the entry lane is in PASSING.
    entry_sensor = 1'b1;
    wait_entry_open("reset_case_open", w);
    entry_pass_sensor = 1'b1;
    tick(10);
    chk("passing_barrier_open", int'(entry_barrier_open), 1);
    #2 reset = 1'b1;
    #1 chk("async_reset_barrier", int'(entry_barrier_open), 0);
    chk("async_reset_fault", int'(gate_fault), 0);
    tick(2);
    entry_pass_sensor = 1'b0;
    entry_sensor = 1'b0;
    reset = 1'b0;
    tick(25);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
